// File: rtl/heater_pkg.sv
// Shared types and constants for the heater PWM driver.
package heater_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam int DUTY_W           = 8;
    localparam int DUTY_MAX         = 255;
    localparam int STEPS_PER_PERIOD = 255;

endpackage

// File: rtl/heater_pwm_driver_if.sv
// Command/status bundle between the PID controller and the heater PWM driver.
interface heater_pwm_driver_if;
    import heater_pkg::*;

    logic              enable;
    logic [DUTY_W-1:0] heater_power;
    logic              power_valid;
    logic              heater_out;
    logic              period_start;
    logic [DUTY_W-1:0] applied_duty;
    logic              fault;

    modport master (
        output enable, heater_power, power_valid,
        input  heater_out, period_start, applied_duty, fault
    );

    modport slave (
        input  enable, heater_power, power_valid,
        output heater_out, period_start, applied_duty, fault
    );

endinterface

// File: rtl/heater_duty_shaper.sv
// Combinational slew limiter plus minimum-pulse quantiser for the PWM duty.
// Slew limiting is compiled in only when HEATER_SLEW_LIMIT_EN is defined.
module heater_duty_shaper
    import heater_pkg::*;
#(
    parameter int MIN_PULSE = 2,
    parameter int SLEW_STEP = 8
) (
    input  logic [DUTY_W-1:0] duty_slew,
    input  logic [DUTY_W-1:0] source,
    output logic [DUTY_W-1:0] next_slew,
    output logic [DUTY_W-1:0] next_applied
);

`ifdef HEATER_SLEW_LIMIT_EN
    localparam bit SLEW_EN = 1'b1;
`else
    localparam bit SLEW_EN = 1'b0;
`endif

    // A limit of DUTY_MAX can never bind, so the slew degenerates to a direct load.
    localparam int STEP_LIM = (!SLEW_EN || (SLEW_STEP > DUTY_MAX)) ? DUTY_MAX : SLEW_STEP;
    localparam logic [DUTY_W-1:0] STEP_V = DUTY_W'(STEP_LIM);
    localparam int LO_MAX = MIN_PULSE - 1;
    localparam int HI_MIN = DUTY_MAX + 1 - MIN_PULSE;

    function automatic logic [DUTY_W-1:0] quantise(input logic [DUTY_W-1:0] d);
        int v;
        v = int'(d);
        if ((d != 8'd0) && (v <= LO_MAX)) begin
            quantise = 8'd0;
        end else if ((v >= HI_MIN) && (d != 8'hFF)) begin
            quantise = 8'hFF;
        end else begin
            quantise = d;
        end
    endfunction

    // Move toward the source by at most STEP_V, landing exactly on it when close
    always_comb begin
        next_slew = duty_slew;
        if (source > duty_slew) begin
            next_slew = ((source - duty_slew) > STEP_V) ? (duty_slew + STEP_V) : source;
        end else if (source < duty_slew) begin
            next_slew = ((duty_slew - source) > STEP_V) ? (duty_slew - STEP_V) : source;
        end else begin
            next_slew = duty_slew;
        end
        next_applied = quantise(next_slew);
    end

endmodule

// File: rtl/heater_pwm_driver.sv
// Fixed-period heater PWM driver with boundary-aligned duty updates and command watchdog.
// Optional slew limiting is selected by HEATER_SLEW_LIMIT_EN (see heater_duty_shaper).
module heater_pwm_driver #(
    parameter int PRESCALE_DIV = 4,
    parameter int MIN_PULSE    = 2,
    parameter int SLEW_STEP    = 8,
    parameter int WDOG_PERIODS = 16
) (
    input logic               clk,
    input logic               reset,
    heater_pwm_driver_if.slave bus
);
    import heater_pkg::*;

    localparam int PRE_W  = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam int WDOG_W = $clog2(WDOG_PERIODS + 1);
    localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(PRESCALE_DIV - 1);
    localparam logic [PRE_W-1:0]  PRE_ONE    = PRE_W'(1);
    localparam logic [DUTY_W-1:0] STEP_LAST  = DUTY_W'(STEPS_PER_PERIOD - 1);
    localparam logic [DUTY_W-1:0] STEP_ONE   = DUTY_W'(1);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_PERIODS);
    localparam logic [WDOG_W-1:0] WDOG_ONE   = WDOG_W'(1);

    state_t            state_r;
    logic [PRE_W-1:0]  pre_cnt_r;
    logic [DUTY_W-1:0] step_cnt_r;
    logic [DUTY_W-1:0] pending_r;
    logic [DUTY_W-1:0] duty_slew_r;
    logic [DUTY_W-1:0] applied_r;
    logic [WDOG_W-1:0] wdog_r;
    logic              heater_out_r;
    logic              period_start_r;
    logic              fault_r;

    logic              tick_s;
    logic              boundary_s;
    logic [DUTY_W-1:0] step_next_s;
    logic [DUTY_W-1:0] source_s;
    logic [WDOG_W-1:0] wdog_next_s;
    logic [DUTY_W-1:0] next_slew_s;
    logic [DUTY_W-1:0] next_applied_s;

    // Period timing, boundary update source and watchdog look-ahead
    always_comb begin
        tick_s      = (pre_cnt_r == PRE_LAST);
        boundary_s  = tick_s && (step_cnt_r == STEP_LAST);
        step_next_s = tick_s ? (step_cnt_r + STEP_ONE) : step_cnt_r;
        source_s    = bus.power_valid ? bus.heater_power : pending_r;
        if (bus.power_valid) begin
            wdog_next_s = '0;
        end else if (wdog_r >= WDOG_LIMIT) begin
            wdog_next_s = wdog_r;
        end else begin
            wdog_next_s = wdog_r + WDOG_ONE;
        end
    end

    heater_duty_shaper #(
        .MIN_PULSE (MIN_PULSE),
        .SLEW_STEP (SLEW_STEP)
    ) u_shaper (
        .duty_slew    (duty_slew_r),
        .source       (source_s),
        .next_slew    (next_slew_s),
        .next_applied (next_applied_s)
    );

    // FSM with counters and outputs registered from next-state values
    always_ff @(posedge clk) begin
        if (reset || !bus.enable) begin
            state_r        <= IDLE;
            pre_cnt_r      <= '0;
            step_cnt_r     <= '0;
            pending_r      <= '0;
            duty_slew_r    <= '0;
            applied_r      <= '0;
            wdog_r         <= '0;
            heater_out_r   <= 1'b0;
            period_start_r <= 1'b0;
            fault_r        <= 1'b0;
        end else begin
            period_start_r <= 1'b0;
            if (bus.power_valid && (state_r != FAULT)) begin
                pending_r <= bus.heater_power;
            end
            case (state_r)
                IDLE: begin
                    state_r        <= RUN;
                    pre_cnt_r      <= '0;
                    step_cnt_r     <= '0;
                    wdog_r         <= '0;
                    duty_slew_r    <= next_slew_s;
                    applied_r      <= next_applied_s;
                    heater_out_r   <= (next_applied_s != 8'd0);
                    period_start_r <= 1'b1;
                    fault_r        <= 1'b0;
                end
                RUN: begin
                    if (!boundary_s) begin
                        pre_cnt_r    <= tick_s ? '0 : (pre_cnt_r + PRE_ONE);
                        step_cnt_r   <= step_next_s;
                        heater_out_r <= (step_next_s < applied_r);
                        if (bus.power_valid) begin
                            wdog_r <= '0;
                        end
                    end else if (wdog_next_s >= WDOG_LIMIT) begin
                        state_r      <= FAULT;
                        pre_cnt_r    <= '0;
                        step_cnt_r   <= '0;
                        wdog_r       <= wdog_next_s;
                        applied_r    <= '0;
                        heater_out_r <= 1'b0;
                        fault_r      <= 1'b1;
                    end else begin
                        pre_cnt_r      <= '0;
                        step_cnt_r     <= '0;
                        wdog_r         <= wdog_next_s;
                        duty_slew_r    <= next_slew_s;
                        applied_r      <= next_applied_s;
                        heater_out_r   <= (next_applied_s != 8'd0);
                        period_start_r <= 1'b1;
                    end
                end
                FAULT: begin
                    pre_cnt_r    <= '0;
                    step_cnt_r   <= '0;
                    applied_r    <= '0;
                    heater_out_r <= 1'b0;
                    fault_r      <= 1'b1;
                end
                default: begin
                    state_r      <= IDLE;
                    applied_r    <= '0;
                    heater_out_r <= 1'b0;
                    fault_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.heater_out   = heater_out_r;
    assign bus.period_start = period_start_r;
    assign bus.applied_duty = applied_r;
    assign bus.fault        = fault_r;

endmodule
